// File: rtl/fpu_op_sequencer.sv
// Single-outstanding FPU initiator: launches registered operands, waits the per-op
// pipeline latency, captures the FPU result and returns it with its tag.
module fpu_op_sequencer #(
    parameter int unsigned LAT_ADD = 3,
    parameter int unsigned LAT_SUB = 3,
    parameter int unsigned LAT_MUL = 3,
    parameter int unsigned LAT_DIV = 3,
    parameter int unsigned TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_opcode,
    input  logic [31:0]      fpu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [1:0]       rsp_op,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [15:0]      ops_done
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_cnt;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_fpu_a;
    logic [31:0]        r_fpu_b;
    logic [1:0]         r_fpu_op;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_result;
    logic [1:0]         r_rsp_op;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic [15:0]        r_ops_done;

    logic               w_accept;
    logic               w_done;
    logic               w_hs;
    logic [7:0]         w_lat_m1;

    assign req_ready = (r_state == StIdle) && !rst;
    assign busy      = (r_state != StIdle);
    assign w_accept  = req_valid && req_ready;
    assign w_done    = (r_state == StWait) && (r_cnt == 8'd0);
    assign w_hs      = (r_state == StResp) && r_rsp_valid && rsp_ready;

    always_comb begin
        w_lat_m1 = 8'(LAT_ADD - 1);
        case (req_op)
            2'd1:    w_lat_m1 = 8'(LAT_SUB - 1);
            2'd2:    w_lat_m1 = 8'(LAT_MUL - 1);
            2'd3:    w_lat_m1 = 8'(LAT_DIV - 1);
            default: w_lat_m1 = 8'(LAT_ADD - 1);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_nxt = StWait;
            StWait:  if (w_done) w_state_nxt = StResp;
            StResp:  if (w_hs) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FPU-facing operands only change on acceptance so the FPU output mux stays quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= 8'd0;
            r_tag        <= '0;
            r_fpu_a      <= 32'd0;
            r_fpu_b      <= 32'd0;
            r_fpu_op     <= 2'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_op     <= 2'd0;
            r_rsp_tag    <= '0;
            r_ops_done   <= 16'd0;
        end else begin
            if (w_accept) begin
                r_fpu_a  <= req_a;
                r_fpu_b  <= req_b;
                r_fpu_op <= req_op;
                r_tag    <= req_tag;
                r_cnt    <= w_lat_m1;
            end
            if ((r_state == StWait) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_done) begin
                r_rsp_result <= fpu_result;
                r_rsp_op     <= r_fpu_op;
                r_rsp_tag    <= r_tag;
                r_rsp_valid  <= 1'b1;
            end
            if (w_hs) begin
                r_rsp_valid <= 1'b0;
                r_ops_done  <= r_ops_done + 16'd1;
            end
        end
    end

    assign fpu_a      = r_fpu_a;
    assign fpu_b      = r_fpu_b;
    assign fpu_opcode = r_fpu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_op     = r_rsp_op;
    assign rsp_tag    = r_rsp_tag;
    assign ops_done   = r_ops_done;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer with a stand-in FPU that only presents a
// correct result once the op's pipeline latency has elapsed since launch.
module tb_fpu_op_sequencer;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_a = 32'd0;
    logic [31:0]      req_b = 32'd0;
    logic [1:0]       req_op = 2'd0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic [1:0]       fpu_opcode;
    logic [31:0]      fpu_result;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_result;
    logic [1:0]       rsp_op;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic [15:0]      ops_done;

    fpu_op_sequencer #(
        .LAT_ADD(1), .LAT_SUB(3), .LAT_MUL(5), .LAT_DIV(7), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_op(rsp_op), .rsp_tag(rsp_tag), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      res;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               acc;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rp_mode = 0;   // 0: ready high, 1: ready low, 2: random
    logic        in_flight = 1'b0;
    logic        prev_v = 1'b0;
    logic        have_cur = 1'b0;
    logic [15:0] exp_done = 16'd0;
    logic [31:0] last_a = 32'd0;
    logic [31:0] last_b = 32'd0;
    logic [1:0]  last_op = 2'd0;

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'd0:    return 1;
            2'd1:    return 3;
            2'd2:    return 5;
            default: return 7;
        endcase
    endfunction

    // Stand-in FPU arithmetic on raw bits; the sequencer never interprets values.
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return (b == 32'd0) ? 32'h7FC00000 : a / b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    logic acc_next = 1'b0;
    int   age = 0;
    always @(negedge clk) acc_next <= req_valid && req_ready;
    always @(posedge clk) age <= acc_next ? 1 : ((age < 1000) ? age + 1 : age);
    always_comb begin
        fpu_result = 32'hDEAD0000 | 32'(age);
        if (age >= lat_of(fpu_opcode)) fpu_result = fpu_fn(fpu_a, fpu_b, fpu_opcode);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: checks every cycle; pops the scoreboard when a response first appears.
    initial begin
        logic hs;
        forever begin
            @(negedge clk);
            hs = 1'b0;
            if (rst) begin
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_ops_done", 32'(ops_done), 32'd0);
                chk("rst_fpu_a", fpu_a, 32'd0);
            end else begin
                chk("ops_done", 32'(ops_done), 32'(exp_done));
                chk("req_ready", 32'(req_ready), 32'(!in_flight));
                chk("busy", 32'(busy), 32'(in_flight));
                chk("fpu_a", fpu_a, last_a);
                chk("fpu_b", fpu_b, last_b);
                chk("fpu_opcode", 32'(fpu_opcode), 32'(last_op));
                if (rsp_valid) begin
                    if (!prev_v) begin
                        if (q.size() == 0) begin
                            chk("unexpected_rsp_queue", 32'd0, 32'd1);
                            have_cur = 1'b0;
                        end else begin
                            cur = q.pop_front();
                            have_cur = 1'b1;
                            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                        end
                    end
                    if (have_cur) begin
                        chk("rsp_result", rsp_result, cur.res);
                        chk("rsp_op", 32'(rsp_op), 32'(cur.op));
                        chk("rsp_tag", 32'(rsp_tag), 32'(cur.tag));
                    end
                    hs = rsp_ready;
                end
                prev_v = rsp_valid && !hs;
            end
            @(posedge clk);
            if (hs) begin
                exp_done = exp_done + 16'd1;
                in_flight = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [TAG_W-1:0] tag, output int acc);
        exp_t e;
        int   n;
        req_a = a;
        req_b = b;
        req_op = op;
        req_tag = tag;
        req_valid = 1'b1;
        acc = -1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(posedge clk);
        e.res = fpu_fn(a, b, op);
        e.op = op;
        e.tag = tag;
        e.lat = lat_of(op);
        e.acc = acc;
        q.push_back(e);
        last_a = a;
        last_b = b;
        last_op = op;
        in_flight = 1'b1;
        #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_a = $urandom;
        req_b = $urandom;
        req_op = 2'($urandom);
        req_tag = 4'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((in_flight || q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("idle_timeout", 32'(in_flight), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int fall_cyc;
        int n;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Directed add, then back-to-back mul/div with req_valid held high.
        issue(32'h3F800000, 32'h40000000, 2'd0, 4'd5, acc);
        idle_req();
        wait_idle();
        chk("ops_done_after_add", 32'(ops_done), 32'd1);
        issue(32'h40000000, 32'h40400000, 2'd2, 4'd1, acc);
        issue(32'h40C00000, 32'h40000000, 2'd3, 4'd2, acc);
        idle_req();
        wait_idle();

        // Backpressure: hold rsp_ready low for 10 cycles after rsp_valid.
        rp_mode = 1;
        issue(32'h12345678, 32'h00000003, 2'd1, 4'd9, acc);
        idle_req();
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (10) @(negedge clk);
        chk("bp_ops_done_held", 32'(ops_done), 32'd3);
        rp_mode = 0;
        wait_idle();
        chk("bp_ops_done_once", 32'(ops_done), 32'd4);

        // Per-op latency extremes, div by zero passes through.
        issue(32'h40E00000, 32'h00000000, 2'd3, 4'd7, acc);
        issue(32'h7F800000, 32'h00800000, 2'd0, 4'd8, acc);
        idle_req();
        wait_idle();

        // Randomized traffic with random backpressure and gaps.
        rp_mode = 2;
        for (int i = 0; i < 150; i++) begin
            issue($urandom, $urandom, 2'($urandom), 4'($urandom), acc);
            if ($urandom_range(0, 2) == 0) begin
                idle_req();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        idle_req();
        rp_mode = 0;
        wait_idle();

        // Asynchronous reset mid-WAIT drops the op.
        issue(32'h00000064, 32'h00000005, 2'd3, 4'd3, acc);
        idle_req();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_fpu_a", fpu_a, 32'd0);
        chk("arst_fpu_b", fpu_b, 32'd0);
        chk("arst_fpu_opcode", 32'(fpu_opcode), 32'd0);
        chk("arst_rsp_result", rsp_result, 32'd0);
        chk("arst_rsp_op", 32'(rsp_op), 32'd0);
        chk("arst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("arst_ops_done", 32'(ops_done), 32'd0);
        q.delete();
        in_flight = 1'b0;
        prev_v = 1'b0;
        exp_done = 16'd0;
        last_a = 32'd0;
        last_b = 32'd0;
        last_op = 2'd0;
        repeat (3) @(posedge clk);
        req_a = 32'h00000011;
        req_b = 32'h00000022;
        req_op = 2'd1;
        req_tag = 4'd12;
        req_valid = 1'b1;
        #3 rst = 1'b0;
        fall_cyc = cyc;
        issue(32'h00000011, 32'h00000022, 2'd1, 4'd12, acc);
        chk("accept_after_rst", 32'(acc), 32'(fall_cyc + 1));
        idle_req();
        repeat (20) @(posedge clk);
        wait_idle();

        // Counter wrap from 0xFFFF.
        force dut.r_ops_done = 16'hFFFF;
        exp_done = 16'hFFFF;
        @(posedge clk);
        #1 release dut.r_ops_done;
        issue(32'h00000001, 32'h00000001, 2'd0, 4'd15, acc);
        idle_req();
        wait_idle();
        chk("ops_done_wrap", 32'(ops_done), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Initiator-side controller that feeds the FPU.
- Accepts tagged operation requests (A, B, opcode) on a valid/ready interface.
- Drives registered operands and opcode to the FPU, waits the per-operation pipeline latency, then captures the FPU result.
- Returns the result with its tag on a valid/ready response interface.
- Sits between the instruction/command front end and the FPU. Exactly one operation is outstanding at a time.

Parameters:
- LAT_ADD, 3, cycles from operand launch to valid add result (1..255)
- LAT_SUB, 3, cycles from operand launch to valid sub result (1..255)
- LAT_MUL, 3, cycles from operand launch to valid mul result (1..255)
- LAT_DIV, 3, cycles from operand launch to valid div result (1..255)
- TAG_W, 4, request/response tag width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a  in  32  IEEE-754 single operand A
- req_b  in  32  IEEE-754 single operand B
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div
- req_tag  in  TAG_W  opaque request ID
- fpu_a  out  32  operand A to FPU
- fpu_b  out  32  operand B to FPU
- fpu_opcode  out  2  opcode to FPU
- fpu_result  in  32  FPU result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  captured FPU result
- rsp_op  out  2  opcode of the completed operation
- rsp_tag  out  TAG_W  tag of the completed operation
- busy  out  1  state != IDLE
- ops_done  out  16  completed-response counter

Behaviour:
- Clock: one clock, clk. Reset: rst is asynchronous and active-high. While rst is high, all state is held at reset values.
- Reset values:
  - state = IDLE
  - fpu_a, fpu_b, fpu_opcode = 0
  - rsp_valid = 0; rsp_result, rsp_op, rsp_tag = 0
  - ops_done = 0
  - wait counter = 0
  - req_ready = 0 while rst is high; busy = 0
- req_ready = (state == IDLE) and not rst. It is combinational from state and does not depend on req_valid.
- FSM states and transitions:
  - IDLE: on an edge with req_valid and req_ready:
    - register req_a, req_b, req_op into fpu_a, fpu_b, fpu_opcode;
    - register req_tag and req_op internally;
    - load the counter with LAT_x - 1 for the selected op;
    - go to WAIT.
  - WAIT: fpu_a, fpu_b and fpu_opcode are held stable.
    - If counter != 0: decrement the counter.
    - If counter == 0: capture fpu_result into rsp_result, set rsp_op and rsp_tag, set rsp_valid = 1, go to RESP.
  - RESP: rsp_valid is held with stable payload until rsp_ready is high.
    - On the edge with rsp_valid and rsp_ready: clear rsp_valid, increment ops_done, go to IDLE.
- Latency:
  - rsp_valid rises exactly LAT_x cycles after the request-acceptance edge.
  - A request accepted at edge E0 gives rsp_valid high after edge E0+LAT_x.
  - With rsp_ready held high, the next request can be accepted at edge E0+LAT_x+2.
- Throughput: one operation per LAT_x + 2 cycles. req_ready is low for the whole of WAIT and RESP.
- FPU outputs keep their last values in IDLE and RESP; they never return to 0 except on reset. fpu_opcode therefore stays stable so the FPU output mux does not glitch.
- rsp_result is a registered capture. Later changes on fpu_result do not affect it.
- req_* inputs are ignored when req_ready is low, and are not sampled outside the acceptance edge.
- ops_done wraps from 0xFFFF to 0x0000.
- Reset mid-operation: an in-flight op is dropped and no response is produced. After rst falls, the block is in IDLE with req_ready = 1 from the first cycle.
- The sequencer does not inspect operand or result values. NaN, Inf and divide-by-zero are passed through exactly as the FPU produces them.

Test Plan:
- Add, defaults: req A=0x3F800000 (1.0), B=0x40000000 (2.0), op=00, tag=5, rsp_ready=1.
  - Expect fpu_a, fpu_b, fpu_opcode stable for 3 cycles.
  - Expect rsp_valid 3 cycles after acceptance with rsp_result=0x40400000, rsp_tag=5, rsp_op=00; ops_done=1.
- Back-to-back mixed ops: mul 2.0*3.0 (tag 1) then div 6.0/2.0 (tag 2), with req_valid held high.
  - Expect req_ready low during WAIT/RESP.
  - Expect results 0x40C00000 then 0x40400000, in order, with tags 1 then 2.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - Expect rsp_valid, rsp_result and rsp_tag stable and req_ready=0.
  - On rsp_ready=1, expect a single handshake and ops_done increment by 1.
- Per-op latency: LAT_DIV=7, LAT_ADD=1.
  - Div: rsp_valid at exactly accept+7.
  - Add: rsp_valid at exactly accept+1.
- Reset mid-op: assert rst asynchronously (not on a clock edge) during WAIT.
  - Expect immediate rsp_valid=0, busy=0, all outputs 0, and no response after rst falls.
  - Expect a new request to be accepted on the first edge after rst deasserts.
- Counter wrap: preload by running 65536 ops (or force the counter to 0xFFFF).
  - Expect ops_done to wrap to 0x0000 on the next response handshake.
